ysyx_24080006_icache_dm: RTL and testbench
==========================================

Name: ysyx_24080006_icache_dm

Overview:
- Direct-mapped instruction cache directly upstream of the fetch stage.
- Accepts word-aligned fetch addresses from the IFU and returns one 32-bit word per request.
- On a miss, refills a full line over an AXI4 read burst.
- Fetches from the uncached region are serviced with single-beat AXI reads, bypassing the arrays. Supports fence.i invalidation and emits per-request hit/miss/skip pulses for perf counters.

Parameters:
- NUM_LINES, 16, number of lines; power of 2, >=2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, >=2.
- UNC_BASE, 32'h1000_0000, base of the uncached region.
- UNC_MASK, 32'hF000_0000, address bits compared against UNC_BASE.

Ports:
- clock  in  1  clock
- reset  in  1  async active-high reset
- fencei  in  1  invalidate all lines (level, sampled in IDLE)
- fetch_addr  in  32  word-aligned fetch address; [1:0] ignored
- ifu2icu_valid  in  1  request valid
- icu2ifu_ready  out  1  request accepted when valid&ready
- icu2ifu_valid  out  1  response valid
- ifu2icu_ready  in  1  response consumed when valid&ready
- ic_val  out  32  fetched word
- icache_hit / icache_miss / icache_skip  out  1 each  one-cycle pulses, one per accepted request
- araddr out 32, arvalid out 1, arready in 1, arlen out 8, arsize out 3, arburst out 2  (AXI AR channel)
- rdata in 32, rresp in 2, rlast in 1, rvalid in 1, rready out 1  (AXI R channel)

Behaviour:
- Clock is `clock`. Reset is `reset`: one clock, asynchronous, active-high.
- Address split: offset = log2(LINE_WORDS)+2 bits; index = log2(NUM_LINES) bits; tag = remaining upper bits.
- Storage: valid bit and tag per line, plus a data array. Uncached test: (fetch_addr & UNC_MASK) == UNC_BASE.
- Reset values: all valid bits 0; state IDLE; icu2ifu_ready=0 during reset; icu2ifu_valid=0; arvalid=0; rready=0; ic_val=0; all perf pulses 0. Tags and data are not reset.
- Asynchronous reset mid-burst abandons the transaction. The interconnect is reset with the core.

State machine: IDLE, RESP, AR, R.
- IDLE:
  - icu2ifu_ready=1.
  - fencei=1: clear all valid bits this cycle; no request is accepted that cycle (ready=0).
  - Request accepted and cacheable hit: latch word into ic_val, pulse icache_hit, go RESP. Latency is 1 cycle: response valid the cycle after acceptance.
  - Cacheable miss: pulse icache_miss, latch address, go AR.
  - Uncached: pulse icache_skip, latch address, go AR.
- AR:
  - arvalid=1. Miss: araddr is the line-aligned address, arlen=LINE_WORDS-1. Uncached: araddr = word address, arlen=0.
  - arsize=3'b010, arburst=2'b01 (INCR).
  - Hold all AR signals stable until arready; then go R.
- R:
  - rready=1. Beat counter starts at 0 and increments on each rvalid&rready.
  - Miss: each beat is written to data[index][beat]. The beat equal to the requested word offset is captured into ic_val.
  - Uncached: the single beat is captured into ic_val.
  - On rvalid&rready&rlast: go RESP. For a miss, write tag and set valid only if every beat returned rresp==OKAY; otherwise the line stays invalid and ic_val still returns the captured data.
  - rlast arriving earlier than expected is treated as end of burst.
- RESP:
  - icu2ifu_valid=1; ic_val held stable.
  - On ifu2icu_ready: go IDLE.
  - fencei asserted in RESP/AR/R is not lost. It is latched and applied on the next IDLE cycle, before any new acceptance.
- Throughput: one outstanding request; minimum 2 cycles per hit (accept + response).
- Perf pulses are exactly one cycle, coincident with request acceptance, and mutually exclusive.

Test Plan:
- Cold miss: request 0x3000_0004 after reset -> icache_miss pulse; AR araddr=0x3000_0000, arlen=3. Beats 0x11,0x22,0x33,0x44 -> icu2ifu_valid with ic_val=0x22 the cycle after rlast.
- Hit: request 0x3000_000C after the fill -> icache_hit, no AR activity, ic_val=0x44 exactly 1 cycle after acceptance.
- Conflict eviction: request 0x3000_0100 (same index, different tag) -> miss and refill. Re-request 0x3000_0004 -> miss again.
- fence.i: assert fencei for one cycle in IDLE, then request 0x3000_0100 -> miss. fencei pulsed during an R burst -> the next request after it is also a miss.
- Uncached: request 0x1000_0008 -> icache_skip; AR araddr=0x1000_0008, arlen=0. Repeat -> skip again, never a hit.
- Backpressure and error: hold ifu2icu_ready=0 for 5 cycles -> icu2ifu_valid and ic_val stable throughout. Miss with rresp=SLVERR on beat 1 -> data returned, line not valid, next access to the same address misses.

Source files
------------

// File: rtl/ysyx_24080006_icache_dm.sv
// Direct-mapped instruction cache in front of the fetch stage.
// Line refills use AXI4 INCR bursts; uncached fetches use single beats.
module ysyx_24080006_icache_dm #(
   parameter int          NUM_LINES  = 16,
   parameter int          LINE_WORDS = 4,
   parameter logic [31:0] UNC_BASE   = 32'h1000_0000,
   parameter logic [31:0] UNC_MASK   = 32'hF000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fencei,
   input  logic [31:0] fetch_addr,
   input  logic        ifu2icu_valid,
   output logic        icu2ifu_ready,
   output logic        icu2ifu_valid,
   input  logic        ifu2icu_ready,
   output logic [31:0] ic_val,
   output logic        icache_hit,
   output logic        icache_miss,
   output logic        icache_skip,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
);
   localparam int WO_W  = $clog2(LINE_WORDS);
   localparam int OFF_W = WO_W + 2;
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - OFF_W - IDX_W;
   localparam logic [31:0] LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
   localparam logic [WO_W-1:0] LAST_BEAT = WO_W'(LINE_WORDS - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RESP = 2'd1;
   localparam logic [1:0] S_AR   = 2'd2;
   localparam logic [1:0] S_R    = 2'd3;

   logic [1:0]           state_q;
   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

   logic [IDX_W-1:0] req_idx;
   logic [WO_W-1:0]  req_woff;
   logic             req_unc;
   logic [WO_W-1:0]  beat_q;
   logic             err_q;
   logic             fence_pend_q;
   logic [31:0]      araddr_q;
   logic [7:0]       arlen_q;

   logic [IDX_W-1:0] f_idx;
   logic [WO_W-1:0]  f_woff;
   logic [TAG_W-1:0] f_tag;
   logic             f_unc;
   logic             line_hit;
   logic             accept;
   logic             beat_fire;

   assign f_idx    = fetch_addr[OFF_W+IDX_W-1:OFF_W];
   assign f_woff   = fetch_addr[OFF_W-1:2];
   assign f_tag    = fetch_addr[31:OFF_W+IDX_W];
   assign f_unc    = (fetch_addr & UNC_MASK) == UNC_BASE;
   assign line_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

   // A pending or live fence.i owns the IDLE cycle, so nothing is accepted
   assign icu2ifu_ready = !reset && (state_q == S_IDLE)
                          && !fencei && !fence_pend_q;
   assign accept    = ifu2icu_valid && icu2ifu_ready;
   assign beat_fire = rvalid && rready;

   assign icache_hit  = accept && !f_unc && line_hit;
   assign icache_miss = accept && !f_unc && !line_hit;
   assign icache_skip = accept && f_unc;

   assign icu2ifu_valid = (state_q == S_RESP);
   assign arvalid       = (state_q == S_AR);
   assign rready        = (state_q == S_R);
   assign araddr        = araddr_q;
   assign arlen         = arlen_q;
   assign arsize        = 3'b010;
   assign arburst       = 2'b01;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         valid_q      <= '0;
         fence_pend_q <= 1'b0;
         ic_val       <= 32'd0;
         req_idx      <= '0;
         req_woff     <= '0;
         req_unc      <= 1'b0;
         beat_q       <= '0;
         err_q        <= 1'b0;
         araddr_q     <= 32'd0;
         arlen_q      <= 8'd0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (fencei || fence_pend_q) begin
                  valid_q      <= '0;
                  fence_pend_q <= 1'b0;
               end else if (accept) begin
                  req_idx  <= f_idx;
                  req_woff <= f_woff;
                  req_unc  <= f_unc;
                  beat_q   <= '0;
                  err_q    <= 1'b0;
                  if (!f_unc && line_hit) begin
                     ic_val  <= data_q[f_idx][f_woff];
                     state_q <= S_RESP;
                  end else begin
                     // the line is rewritten, so drop it until the fill proves good
                     if (!f_unc) valid_q[f_idx] <= 1'b0;
                     araddr_q <= f_unc ? (fetch_addr & WORD_MASK)
                                       : (fetch_addr & LINE_MASK);
                     arlen_q  <= f_unc ? 8'd0 : 8'(LINE_WORDS - 1);
                     state_q  <= S_AR;
                  end
               end
            end
            S_AR: begin
               if (arready) state_q <= S_R;
            end
            S_R: begin
               if (beat_fire) begin
                  beat_q <= beat_q + WO_W'(1);
                  if (rresp != 2'b00) err_q <= 1'b1;
                  if (req_unc || beat_q == req_woff) ic_val <= rdata;
                  if (rlast) begin
                     state_q <= S_RESP;
                     if (!req_unc && !err_q && rresp == 2'b00
                         && beat_q == LAST_BEAT)
                        valid_q[req_idx] <= 1'b1;
                  end
               end
            end
            S_RESP: begin
               if (ifu2icu_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
         if (fencei && state_q != S_IDLE) fence_pend_q <= 1'b1;
      end
   end

   // Tag and data arrays carry no reset; valid_q guards them
   always_ff @(posedge clock) begin
      if (icache_miss) tag_q[f_idx] <= f_tag;
      if (beat_fire && !req_unc) data_q[req_idx][beat_q] <= rdata;
   end
endmodule

// File: tb/tb_ysyx_24080006_icache_dm.sv
// Scoreboard bench for the direct-mapped icache with an AXI slave model.
// Expected pulses, AR requests and responses are queued at issue time.
module tb_ysyx_24080006_icache_dm;
   localparam int NL = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        fencei;
   logic [31:0] fetch_addr;
   logic        ifu2icu_valid;
   logic        icu2ifu_ready;
   logic        icu2ifu_valid;
   logic        ifu2icu_ready;
   logic [31:0] ic_val;
   logic        icache_hit, icache_miss, icache_skip;
   logic [31:0] araddr;
   logic        arvalid, arready;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;

   always #5 clock = ~clock;

   ysyx_24080006_icache_dm dut (
      .clock(clock), .reset(reset), .fencei(fencei),
      .fetch_addr(fetch_addr), .ifu2icu_valid(ifu2icu_valid),
      .icu2ifu_ready(icu2ifu_ready), .icu2ifu_valid(icu2ifu_valid),
      .ifu2icu_ready(ifu2icu_ready), .ic_val(ic_val),
      .icache_hit(icache_hit), .icache_miss(icache_miss),
      .icache_skip(icache_skip), .araddr(araddr), .arvalid(arvalid),
      .arready(arready), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .rdata(rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   logic [31:0] mem [logic [31:0]];
   function automatic logic [31:0] mem_rd(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   // reference model: per-line valid and tag, data comes from mem
   bit          ref_v [NL];
   logic [31:0] ref_t [NL];

   logic [31:0] rsp_q [$];
   logic [2:0]  kind_q [$];
   logic [39:0] ar_q [$];
   int rsp_done = 0;
   int err_beat = -1;
   bit fence_in_r = 1'b0;
   int bp_left = 0;

   // response monitor: value checked every valid cycle, popped on handshake
   always @(negedge clock) begin
      if (!reset && icu2ifu_valid) begin
         if (rsp_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
         else begin
            chk("rsp_data", ic_val, rsp_q[0]);
            if (ifu2icu_ready) begin
               void'(rsp_q.pop_front());
               rsp_done++;
            end
         end
      end
   end

   // perf pulse monitor
   always @(negedge clock) begin
      logic [31:0] np;
      logic        acc;
      np  = 32'(icache_hit) + 32'(icache_miss) + 32'(icache_skip);
      acc = ifu2icu_valid && icu2ifu_ready;
      if (!reset && (acc || np != 0)) begin
         chk("pulse_onehot", np, 32'd1);
         chk("pulse_at_accept", 32'(acc), 32'd1);
         if (kind_q.size() == 0) chk("pulse_unexpected", 32'd1, 32'd0);
         else chk("pulse_kind", 32'({icache_hit, icache_miss, icache_skip}),
                  32'(kind_q.pop_front()));
      end
   end

   // AR channel monitor
   logic        ar_wait = 1'b0;
   logic [39:0] ar_prev;
   always @(negedge clock) begin
      if (!reset && arvalid) begin
         chk("arsize", 32'(arsize), 32'd2);
         chk("arburst", 32'(arburst), 32'd1);
         if (ar_wait) chk("ar_stable", 32'({araddr, arlen} != ar_prev), 32'd0);
         if (arready) begin
            ar_wait = 1'b0;
            if (ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
            else begin
               logic [39:0] e;
               e = ar_q.pop_front();
               chk("araddr", araddr, e[39:8]);
               chk("arlen", 32'(arlen), 32'(e[7:0]));
            end
         end else begin
            ar_wait = 1'b1;
            ar_prev = {araddr, arlen};
         end
      end
   end

   // AXI slave with random AR and R stalls
   initial begin
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      rdata = 32'd0; rresp = 2'b00;
      forever begin
         logic [31:0] a;
         int l;
         @(posedge clock); #1;
         if (!arvalid) continue;
         a = araddr;
         l = int'(arlen);
         repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
         arready = 1'b1;
         @(posedge clock); #1;
         arready = 1'b0;
         for (int b = 0; b <= l; b++) begin
            rvalid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
            rvalid = 1'b1;
            rdata  = mem_rd(a + 32'(b * 4));
            rresp  = (l != 0 && b == err_beat) ? 2'b10 : 2'b00;
            rlast  = (b == l);
            @(posedge clock); #1;
         end
         rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end
   end

   // response consumer with optional forced backpressure
   initial begin
      ifu2icu_ready = 1'b1;
      forever begin
         @(posedge clock); #1;
         if (icu2ifu_valid && bp_left > 0) begin
            ifu2icu_ready = 1'b0;
            bp_left--;
         end else ifu2icu_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // one-cycle fence.i pulse while a burst is in flight
   initial begin
      fencei = 1'b0;
      forever begin
         @(posedge clock); #1;
         if (fence_in_r && rready) begin
            fencei = 1'b1;
            @(posedge clock); #1;
            fencei = 1'b0;
            fence_in_r = 1'b0;
         end
      end
   end

   task automatic issue(logic [31:0] a, bit fence_mid = 1'b0);
      logic [31:0] la;
      int idx, n, target;
      logic [31:0] tg;
      logic [2:0] k;
      la  = a & 32'hFFFF_FFFC;
      idx = int'((la >> 4) % NL);
      tg  = la >> 8;
      if ((a & 32'hF000_0000) == 32'h1000_0000) begin
         k = 3'b001;
         err_beat = -1;
         ar_q.push_back({la, 8'd0});
      end else if (ref_v[idx] && ref_t[idx] == tg) begin
         k = 3'b100;
      end else begin
         k = 3'b010;
         ar_q.push_back({la & 32'hFFFF_FFF0, 8'd3});
         ref_t[idx] = tg;
         ref_v[idx] = (err_beat < 0);
      end
      if (fence_mid) begin
         fence_in_r = 1'b1;
         foreach (ref_v[i]) ref_v[i] = 1'b0;
      end
      kind_q.push_back(k);
      rsp_q.push_back(mem_rd(la));
      target = rsp_done + 1;
      fetch_addr = a;
      ifu2icu_valid = 1'b1;
      for (n = 0; n < 100; n++) begin
         @(negedge clock);
         if (icu2ifu_ready) break;
      end
      if (n == 100) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clock); #1;
      ifu2icu_valid = 1'b0;
      fetch_addr = $urandom;
      if (k == 3'b100) chk("hit_latency", 32'(icu2ifu_valid), 32'd1);
      for (n = 0; n < 300 && rsp_done < target; n++) @(negedge clock);
      if (rsp_done < target) chk("rsp_timeout", 32'(rsp_done), 32'(target));
      err_beat = -1;
      @(posedge clock); #1;
   endtask

   task automatic fence_idle();
      @(posedge clock); #1;
      fencei = 1'b1;
      @(negedge clock);
      chk("fence_blocks_accept", 32'(icu2ifu_ready), 32'd0);
      @(posedge clock); #1;
      fencei = 1'b0;
      foreach (ref_v[i]) ref_v[i] = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      ifu2icu_valid = 1'b0;
      fetch_addr = 32'd0;
      foreach (ref_v[i]) ref_v[i] = 1'b0;
      mem[32'h3000_0000] = 32'h11;
      mem[32'h3000_0004] = 32'h22;
      mem[32'h3000_0008] = 32'h33;
      mem[32'h3000_000C] = 32'h44;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_ready", 32'(icu2ifu_ready), 32'd0);
      chk("rst_valid", 32'(icu2ifu_valid), 32'd0);
      chk("rst_arvalid", 32'(arvalid), 32'd0);
      chk("rst_rready", 32'(rready), 32'd0);
      chk("rst_ic_val", ic_val, 32'd0);
      chk("rst_pulses", 32'({icache_hit, icache_miss, icache_skip}), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;

      issue(32'h3000_0004);
      issue(32'h3000_000C);
      issue(32'h3000_0100);
      issue(32'h3000_0004);
      fence_idle();
      issue(32'h3000_0004);
      fence_idle();
      issue(32'h3000_0100);
      issue(32'h3000_0040, 1'b1);
      issue(32'h3000_0040);
      issue(32'h1000_0008);
      issue(32'h1000_0008);
      bp_left = 5;
      issue(32'h3000_0048);
      err_beat = 1;
      issue(32'h3000_0208);
      issue(32'h3000_0208);

      for (int i = 0; i < 300; i++) begin
         int r;
         r = $urandom_range(0, 15);
         if (r == 0) fence_idle();
         else if (r < 3)
            issue(32'h1000_0000 | (32'($urandom_range(0, 63)) << 2)
                  | 32'($urandom_range(0, 3)));
         else begin
            if ($urandom_range(0, 9) == 0) err_beat = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) bp_left = $urandom_range(1, 6);
            issue(32'h3000_0000 + (32'($urandom_range(0, 511)) << 2)
                  + 32'($urandom_range(0, 3)));
         end
      end

      repeat (5) @(posedge clock);
      chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
      chk("ar_queue_drained", 32'(ar_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
